// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - oversampling asynchronous serial receiver with parity and stop-bit checking
// Frame results are registered together and announced by a one-cycle received pulse.
module serial_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              received,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_W - 1);
  localparam logic             PAR_ODD     = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, WAIT_HIGH
  } state_e;

  state_e            state_q, state_d;
  logic              rxd_meta_q, rxd_s_q, rxd_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              stop_idx_q, stop_idx_d;
  logic              perr_acc_q, perr_acc_d;
  logic              ferr_acc_q, ferr_acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              received_q, received_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;

  logic fall, expire, last_stop, ferr_now;

  assign fall      = rxd_prev_q & ~rxd_s_q;
  assign expire    = (cnt_q == '0);
  assign last_stop = (STOP_BITS == 1) || stop_idx_q;
  assign ferr_now  = ferr_acc_q | ~rxd_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_q   <= 1'b1;
      rxd_s_q      <= 1'b1;
      rxd_prev_q   <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      stop_idx_q   <= 1'b0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      data_q       <= '0;
      received_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rxd_meta_q   <= rxd;
      rxd_s_q      <= rxd_meta_q;
      rxd_prev_q   <= rxd_s_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      stop_idx_q   <= stop_idx_d;
      perr_acc_q   <= perr_acc_d;
      ferr_acc_q   <= ferr_acc_d;
      data_q       <= data_d;
      received_q   <= received_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    stop_idx_d   = stop_idx_q;
    perr_acc_d   = perr_acc_q;
    ferr_acc_d   = ferr_acc_q;
    data_d       = data_q;
    received_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        if (fall) begin
          cnt_d   = HALF_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (!expire) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rxd_s_q) begin
          cnt_d      = FULL_RELOAD;
          idx_d      = '0;
          stop_idx_d = 1'b0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
          state_d    = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!expire) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // LSB arrives first, so shifting in from the top leaves it at bit 0
          shreg_d = {rxd_s_q, shreg_q[DATA_W-1:1]};
          idx_d   = idx_q + 1'b1;
          cnt_d   = FULL_RELOAD;
          if (idx_q == LAST_IDX) begin
            state_d = (PARITY != 0) ? PAR : STOP;
          end
        end
      end
      PAR: begin
        if (!expire) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          perr_acc_d = ((^shreg_q) ^ rxd_s_q) != PAR_ODD;
          cnt_d      = FULL_RELOAD;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (!expire) begin
          cnt_d = cnt_q - 1'b1;
        end else if (last_stop) begin
          data_d       = shreg_q;
          parity_err_d = perr_acc_q;
          frame_err_d  = ferr_now;
          received_d   = 1'b1;
          // Going straight to IDLE lets a start edge in the next cycle be caught
          state_d      = rxd_s_q ? IDLE : WAIT_HIGH;
        end else begin
          ferr_acc_d = ferr_now;
          stop_idx_d = 1'b1;
          cnt_d      = FULL_RELOAD;
        end
      end
      WAIT_HIGH: begin
        if (rxd_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data       = data_q;
  assign received   = received_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - directed frame bench for serial_rx (even-parity/1-stop and no-parity/2-stop)
module tb_serial_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd_p, rxd_n;
  logic [7:0] data_p, data_n;
  logic       rcv_p, rcv_n, perr_p, perr_n, ferr_p, ferr_n, busy_p, busy_n;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         cnt_p = 0;
  int         cnt_n = 0;
  int         pulse_cyc_p = 0;
  int         start_cyc = 0;
  logic       busy_seen;
  logic [7:0] log_n [0:3];

  always #5 clk = ~clk;

  serial_rx #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst(rst_n), .rxd(rxd_p), .data(data_p), .received(rcv_p),
    .parity_err(perr_p), .frame_err(ferr_p), .busy(busy_p)
  );

  serial_rx #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(2)) dut_n (
    .clk(clk), .rst(rst_n), .rxd(rxd_n), .data(data_n), .received(rcv_n),
    .parity_err(perr_n), .frame_err(ferr_n), .busy(busy_n)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rcv_p) begin
      cnt_p++;
      pulse_cyc_p = cyc;
    end
    if (rcv_n) begin
      if (cnt_n < 4) log_n[cnt_n] = data_n;
      cnt_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_p(input logic v);
    rxd_p = v;
    hold(16);
  endtask

  task automatic put_n(input logic v);
    rxd_n = v;
    hold(16);
  endtask

  task automatic frame_p(input logic [7:0] d, input logic par, input logic stop);
    start_cyc = cyc;
    put_p(1'b0);
    for (int i = 0; i < 8; i++) put_p(d[i]);
    put_p(par);
    put_p(stop);
  endtask

  task automatic frame_n(input logic [7:0] d);
    put_n(1'b0);
    for (int i = 0; i < 8; i++) put_n(d[i]);
    put_n(1'b1);
    put_n(1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    rxd_p = 1'b1;
    rxd_n = 1'b1;
    hold(3);
    check("rst_data", {24'd0, data_p}, 32'h0);
    check("rst_received", {31'd0, rcv_p}, 32'h0);
    check("rst_parity_err", {31'd0, perr_p}, 32'h0);
    check("rst_frame_err", {31'd0, ferr_p}, 32'h0);
    check("rst_busy", {31'd0, busy_p | busy_n}, 32'h0);
    rst_n = 1'b1;
    hold(5);

    // even parity, good frame
    frame_p(8'hA5, 1'b0, 1'b1);
    hold(4);
    check("a5_pulses", cnt_p, 1);
    check("a5_latency", pulse_cyc_p - start_cyc, 171);
    check("a5_data", {24'd0, data_p}, 32'hA5);
    check("a5_parity_err", {31'd0, perr_p}, 32'h0);
    check("a5_frame_err", {31'd0, ferr_p}, 32'h0);
    check("a5_busy", {31'd0, busy_p}, 32'h0);

    // wrong parity bit still delivers the frame
    frame_p(8'h3C, 1'b1, 1'b1);
    hold(4);
    check("3c_pulses", cnt_p, 2);
    check("3c_data", {24'd0, data_p}, 32'h3C);
    check("3c_parity_err", {31'd0, perr_p}, 32'h1);
    check("3c_frame_err", {31'd0, ferr_p}, 32'h0);

    // 5-cycle glitch is a false start
    busy_seen = 1'b0;
    rxd_p = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) rxd_p = 1'b1;
      hold(1);
      if (busy_p) busy_seen = 1'b1;
    end
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'h1);
    check("glitch_busy_end", {31'd0, busy_p}, 32'h0);
    check("glitch_pulses", cnt_p, 2);
    check("glitch_data", {24'd0, data_p}, 32'h3C);
    check("glitch_parity_err", {31'd0, perr_p}, 32'h1);

    // low stop bit, line held low (break)
    frame_p(8'h55, 1'b0, 1'b0);
    hold(84);
    check("brk_pulses", cnt_p, 3);
    check("brk_data", {24'd0, data_p}, 32'h55);
    check("brk_frame_err", {31'd0, ferr_p}, 32'h1);
    check("brk_parity_err", {31'd0, perr_p}, 32'h0);
    check("brk_wait_high", {31'd0, busy_p}, 32'h1);
    rxd_p = 1'b1;
    hold(4);
    check("brk_release_busy", {31'd0, busy_p}, 32'h0);
    check("brk_release_pulses", cnt_p, 3);

    // reset in the middle of the data bits of 0x81
    put_p(1'b0);
    put_p(1'b1);
    put_p(1'b0);
    put_p(1'b0);
    hold(8);
    rst_n = 1'b0;
    hold(2);
    check("abort_received", {31'd0, rcv_p}, 32'h0);
    check("abort_data", {24'd0, data_p}, 32'h0);
    check("abort_parity_err", {31'd0, perr_p}, 32'h0);
    check("abort_frame_err", {31'd0, ferr_p}, 32'h0);
    check("abort_busy", {31'd0, busy_p}, 32'h0);
    check("abort_pulses", cnt_p, 3);
    rxd_p = 1'b1;
    hold(2);
    rst_n = 1'b1;
    hold(4);
    frame_p(8'h42, 1'b0, 1'b1);
    hold(4);
    check("post_rst_pulses", cnt_p, 4);
    check("post_rst_data", {24'd0, data_p}, 32'h42);
    check("post_rst_errs", {30'd0, perr_p, ferr_p}, 32'h0);

    // back-to-back frames, no parity, two stop bits
    frame_n(8'h01);
    frame_n(8'hFE);
    hold(4);
    check("b2b_pulses", cnt_n, 2);
    check("b2b_first", {24'd0, log_n[0]}, 32'h01);
    check("b2b_second", {24'd0, log_n[1]}, 32'hFE);
    check("b2b_data", {24'd0, data_n}, 32'hFE);
    check("b2b_errs", {30'd0, perr_n, ferr_n}, 32'h0);
    check("b2b_busy", {31'd0, busy_n}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, number of data bits per frame (5..9).
REQ-002 SHALL provide parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (>=4; even values only).
REQ-003 SHALL provide parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL provide parameter STOP_BITS, default 1, stop bits checked per frame (1 or 2).
REQ-005 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL provide port rxd  input  1  asynchronous serial line, idle high.
REQ-008 SHALL provide port data  output  DATA_W  last received data word, LSB first on line.
REQ-009 SHALL provide port received  output  1  one-cycle pulse, frame complete.
REQ-010 SHALL provide port parity_err  output  1  parity mismatch flag of last frame.
REQ-011 SHALL provide port frame_err  output  1  stop-bit low flag of last frame.
REQ-012 SHALL provide port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 SHALL pass rxd through a 2-flop synchroniser (reset value 1); all logic uses synchronised rxd_s only.
REQ-014 SHALL implement states IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
REQ-015 IDLE: on rxd_s falling edge (previous 1, current 0) SHALL load bit counter with CLKS_PER_BIT/2-1 and enter START.
REQ-016 START: at counter expiry SHALL sample rxd_s; 0 -> reload CLKS_PER_BIT-1, clear bit index, enter DATA; 1 -> false start, return to IDLE, no output change.
REQ-017 DATA: at each counter expiry SHALL sample rxd_s into shift register position bit index (LSB first); after DATA_W samples enter PAR if PARITY!=0, else STOP.
REQ-018 PAR: SHALL sample parity bit; mismatch = (XOR of data bits XOR sample) != (PARITY==2 ? 1 : 0).
REQ-019 STOP: SHALL sample STOP_BITS stop bits at CLKS_PER_BIT spacing; any sample 0 sets framing fault.
REQ-020 In the cycle after the final stop sample SHALL update data, parity_err, frame_err together and pulse received for exactly one cycle, including on errored frames.
REQ-021 data, parity_err, frame_err SHALL hold their values until the next received pulse.
REQ-022 After the final stop sample SHALL enter IDLE if rxd_s=1, else WAIT_HIGH; WAIT_HIGH SHALL stay until rxd_s=1 and ignore all edges (break condition).
REQ-023 From IDLE, a falling edge in the same cycle the previous frame completes SHALL be detected (no dead cycle); back-to-back frames SHALL be received without loss.
REQ-024 Counter width SHALL be $clog2(CLKS_PER_BIT); bit index width $clog2(DATA_W+1); no wrap-around shall be observable.
REQ-025 parity_err SHALL remain 0 when PARITY=0.
REQ-026 Latency: received asserts 1 cycle after the middle of the last stop bit, plus 2 cycles synchroniser delay relative to rxd.

Reset
REQ-027 While rst=0, SHALL force state IDLE, data=0, received=0, parity_err=0, frame_err=0, busy=0, synchroniser=1, counters=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no received pulse; after release the receiver SHALL wait for a fresh falling edge.
REQ-029 After reset release the first edge SHALL be accepted no earlier than 2 cycles later (synchroniser refill).

Verification
REQ-030 DATA_W=8, CLKS_PER_BIT=16, PARITY=1: send 0xA5, parity 0, stop 1 -> one received pulse, data=0xA5, parity_err=0, frame_err=0.
REQ-031 Same config: send 0x3C with parity bit 1 -> received pulse, data=0x3C, parity_err=1, frame_err=0.
REQ-032 rxd low for 5 cycles then high in IDLE -> busy high then low, no received pulse, outputs unchanged.
REQ-033 Send 0x55 with stop bit 0 and line held low 100 cycles -> received pulse, frame_err=1, state WAIT_HIGH; falling edges ignored until line returns high.
REQ-034 Two frames 0x01 and 0xFE back-to-back with PARITY=0, STOP_BITS=2 -> two received pulses, data 0x01 then 0xFE, no errors.
REQ-035 Assert rst mid-DATA of frame 0x81 -> no pulse, all outputs 0; next frame 0x42 after release -> data=0x42.
